// File: rtl/id_switch_pkg.sv
// Shared constants and helpers for the ID switch bank: register offsets,
// bus data width and counter sizing.
package id_switch_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned VAL_BASE = 0;

  function automatic int unsigned chg_ofs(input int unsigned n_ch);
    return n_ch;
  endfunction

  function automatic int unsigned irqen_ofs(input int unsigned n_ch);
    return n_ch + 1;
  endfunction

  // Bits needed to hold max_val (never less than one).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/id_switch_debounce.sv
// One switch channel: 2-flop synchroniser, debounce counter, stable latch,
// power-up init suppression and a stretched change indicator.
module id_switch_debounce
  import id_switch_pkg::*;
#(
  parameter int unsigned SW_W       = 4,
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned STRETCH    = 4800000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [SW_W-1:0] i_sw,
  output logic [SW_W-1:0] o_stable,
  output logic            o_chg_c,
  output logic            o_debug
);

  localparam int unsigned CNT_W = cnt_w(DEB_CYCLES - 1);
  localparam int unsigned STR_W = cnt_w(STRETCH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [STR_W-1:0] STR_MAX = STR_W'(STRETCH);

  logic [SW_W-1:0]  r_sync1;
  logic [SW_W-1:0]  r_sync2;
  logic [SW_W-1:0]  r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic [STR_W-1:0] r_stretch;
  logic             r_init;
  logic             r_debug;

  logic             w_done;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_next;
  logic [STR_W-1:0] w_stretch_next;

  assign w_done   = (r_cnt == CNT_MAX);
  assign w_accept = w_done && (r_sync2 != r_stable);
  // The first settled value after reset only arms the channel.
  assign o_chg_c  = w_accept && r_init;
  assign o_stable = r_stable;
  assign o_debug  = r_debug;

  // Counter restarts in the same cycle the synchronised value moves.
  always_comb begin
    w_cnt_next = r_cnt;
    if ((r_sync1 != r_sync2) || w_accept) begin
      w_cnt_next = '0;
    end else if (!w_done) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_stretch_next = r_stretch;
    if (o_chg_c) begin
      w_stretch_next = STR_MAX;
    end else if (r_stretch != '0) begin
      w_stretch_next = r_stretch - STR_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_stable  <= '0;
      r_cnt     <= '0;
      r_stretch <= '0;
      r_init    <= 1'b0;
      r_debug   <= 1'b0;
    end else begin
      r_sync1   <= i_sw;
      r_sync2   <= r_sync1;
      r_cnt     <= w_cnt_next;
      r_stretch <= w_stretch_next;
      r_debug   <= (w_stretch_next != '0);
      if (w_accept) r_stable <= r_sync2;
      if (w_done)   r_init   <= 1'b1;
    end
  end

endmodule

// File: rtl/id_switch_bank.sv
// Bank of debounced ID switch channels behind an Avalon-MM slave with
// sticky change flags, interrupt enables and a level interrupt.
module id_switch_bank
  import id_switch_pkg::*;
#(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned SW_W       = 4,
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned STRETCH    = 4800000,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH*SW_W-1:0] sw,
  output logic [N_CH-1:0]      debug_out,
  input  logic [ADDR_W-1:0]    avs_address,
  input  logic                 avs_read,
  output logic [31:0]          avs_readdata,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic                 irq
);

  localparam logic [ADDR_W-1:0] A_CHG   = ADDR_W'(chg_ofs(N_CH));
  localparam logic [ADDR_W-1:0] A_IRQEN = ADDR_W'(irqen_ofs(N_CH));

  logic [SW_W-1:0]   w_stable [N_CH];
  logic [N_CH-1:0]   w_chg;
  logic [N_CH-1:0]   w_clr;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused_wdata;

  logic [N_CH-1:0]   r_chg;
  logic [N_CH-1:0]   r_irq_en;
  logic [DATA_W-1:0] r_rdata;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    id_switch_debounce #(
      .SW_W       (SW_W),
      .DEB_CYCLES (DEB_CYCLES),
      .STRETCH    (STRETCH)
    ) u_deb (
      .i_clk    (clk),
      .i_rst    (reset),
      .i_sw     (sw[k*SW_W +: SW_W]),
      .o_stable (w_stable[k]),
      .o_chg_c  (w_chg[k]),
      .o_debug  (debug_out[k])
    );
  end

  assign w_clr = (avs_write && (avs_address == A_CHG)) ? avs_writedata[N_CH-1:0] : '0;
  assign w_unused_wdata = &{1'b0, avs_writedata};

  // Read mux sees pre-write, pre-update register contents.
  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (avs_address == ADDR_W'(VAL_BASE + k)) w_rdata = DATA_W'(w_stable[k]);
    end
    if (avs_address == A_CHG)   w_rdata = DATA_W'(r_chg);
    if (avs_address == A_IRQEN) w_rdata = DATA_W'(r_irq_en);
  end

  // A new change beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chg    <= '0;
      r_irq_en <= '0;
      r_rdata  <= '0;
    end else begin
      r_chg <= (r_chg & ~w_clr) | w_chg;
      if (avs_write && (avs_address == A_IRQEN)) r_irq_en <= avs_writedata[N_CH-1:0];
      if (avs_read) r_rdata <= w_rdata;
    end
  end

  assign avs_readdata = r_rdata;
  assign irq          = |(r_chg & r_irq_en);

endmodule

// File: tb/tb_id_switch_bank.sv
// Directed bench for id_switch_bank with a read-data scoreboard and pin checks.
module tb_id_switch_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sw;
  logic [1:0]  debug_out;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic        rd_q = 1'b0;

  id_switch_bank #(
    .N_CH(2), .SW_W(4), .DEB_CYCLES(8), .STRETCH(5), .ADDR_W(5)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .debug_out(debug_out),
    .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: read data is presented one cycle after the strobe.
  always @(posedge clk) rd_q <= avs_read;
  always @(negedge clk) begin
    if (rd_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got %0h expected none", avs_readdata);
      end else begin
        chk(nm_q.pop_front(), avs_readdata, exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    avs_address = a;
    avs_read    = 1'b1;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    @(negedge clk);
    avs_read = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic rw(input logic [4:0] a, input logic [31:0] d, input logic [31:0] exp, input string nm);
    avs_writedata = d;
    avs_write     = 1'b1;
    rd(a, exp, nm);
    avs_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sw = 8'h00; avs_address = '0; avs_read = 1'b0;
    avs_write = 1'b0; avs_writedata = '0;
    step(2);
    chk("rst_debug", 32'(debug_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", avs_readdata, 32'h0);

    // Power-up acceptance of ch0=5 is init only.
    reset = 1'b0; sw = 8'h05;
    step(9);
    rd(5'd0, 32'h0, "stable0_same_cycle_old");
    rd(5'd0, 32'h5, "stable0_init");
    rd(5'd2, 32'h0, "flags_after_init");
    chk("debug_after_init", 32'(debug_out), 32'h0);

    // ch1 0 -> 3, clear, then 3 -> A with stretch measurement.
    sw = 8'h35;
    step(20);
    wr(5'd2, 32'h3);
    sw = 8'hA5;
    step(9);
    chk("dbg1_before", 32'(debug_out[1]), 32'h0);
    rd(5'd1, 32'h3, "ch1_same_cycle_old");
    chk("dbg1_c1", 32'(debug_out[1]), 32'h1);
    rd(5'd1, 32'hA, "ch1_new");
    chk("dbg1_c2", 32'(debug_out[1]), 32'h1);
    rd(5'd2, 32'h2, "flags_ch1");
    chk("dbg1_c3", 32'(debug_out[1]), 32'h1);
    step(1);
    chk("dbg1_c4", 32'(debug_out[1]), 32'h1);
    step(1);
    chk("dbg1_c5", 32'(debug_out[1]), 32'h1);
    step(1);
    chk("dbg1_end", 32'(debug_out[1]), 32'h0);
    wr(5'd2, 32'h2);

    // Bounce on ch0 shorter than the debounce window.
    sw = 8'hA6;
    step(5);
    sw = 8'hA5;
    step(20);
    rd(5'd0, 32'h5, "bounce_stable");
    rd(5'd2, 32'h0, "bounce_flags");
    chk("bounce_irq", 32'(irq), 32'h0);

    // Interrupt set, set-wins-over-clear, then clear.
    wr(5'd3, 32'h3);
    rd(5'd3, 32'h3, "irq_en_rb");
    sw = 8'hA7;
    step(9);
    chk("irq_pre", 32'(irq), 32'h0);
    step(1);
    chk("irq_set", 32'(irq), 32'h1);
    sw = 8'hA5;
    step(9);
    wr(5'd2, 32'h1);
    rd(5'd2, 32'h1, "set_wins");
    chk("irq_still", 32'(irq), 32'h1);
    wr(5'd2, 32'h1);
    chk("irq_clear", 32'(irq), 32'h0);
    rd(5'd2, 32'h0, "flags_cleared");

    // Unmapped addresses and simultaneous read/write.
    rd(5'd4, 32'h0, "unmapped4");
    rd(5'd5, 32'h0, "unmapped5");
    rd(5'd31, 32'h0, "unmapped31");
    wr(5'd4, 32'hFFFF_FFFF);
    wr(5'd5, 32'hFFFF_FFFF);
    wr(5'd31, 32'hFFFF_FFFF);
    rd(5'd0, 32'h5, "post_unmapped_v0");
    rd(5'd1, 32'hA, "post_unmapped_v1");
    rd(5'd2, 32'h0, "post_unmapped_flags");
    rd(5'd3, 32'h3, "post_unmapped_en");
    rw(5'd3, 32'h1, 32'h3, "rw_old_value");
    rd(5'd3, 32'h1, "rw_written");
    wr(5'd3, 32'h3);

    // Reset during ch1 stretch while ch0 is mid-count.
    sw = 8'h35;
    step(6);
    sw = 8'h39;
    step(6);
    chk("pre_rst_debug", 32'(debug_out), 32'h2);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_debug", 32'(debug_out), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_rdata", avs_readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd(5'd1, 32'h0, "post_rst_stable1");
    rd(5'd2, 32'h0, "post_rst_flags");
    step(12);
    rd(5'd0, 32'h9, "reinit_v0");
    rd(5'd1, 32'h3, "reinit_v1");
    rd(5'd2, 32'h0, "reinit_no_flag");
    rd(5'd3, 32'h0, "reinit_irq_en");
    chk("reinit_debug", 32'(debug_out), 32'h0);
    chk("reinit_irq", 32'(irq), 32'h0);

    step(2);
    chk("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_switch_bank.md
Name: id_switch_bank

Overview:
Parametrised successor to the single 4-bit ID switch component: N_CH independent SW_W-bit switch inputs. Each channel is synchronised, debounced and latched, with per-channel change detection and a stretched debug pulse. A Qsys Avalon-MM slave exposes values, sticky change flags and an interrupt, so software on the NINA/SPI-bridge side can poll or take an IRQ instead of reading raw pins.

Parameters:
N_CH, 2, number of switch channels (1..16)
SW_W, 4, bits per switch channel (1..32)
DEB_CYCLES, 50000, consecutive stable clk cycles required to accept a new value (>=2)
STRETCH, 4800000, debug_out high time in clk cycles after an accepted change (>=1)
ADDR_W, 5, Avalon word-address width; must satisfy 2^ADDR_W >= N_CH+2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
sw  in  N_CH*SW_W  raw switch pins; channel k = sw[k*SW_W +: SW_W]
debug_out  out  N_CH  per-channel change indicator (stretched pulse)
avs_address  in  ADDR_W  word address
avs_read  in  1  read strobe
avs_readdata  out  32  read data, valid exactly 1 cycle after avs_read
avs_write  in  1  write strobe
avs_writedata  in  32  write data
irq  out  1  level interrupt = |(chg_flags & irq_en)

Behaviour:
- Reset (async assert, sync release): stable values 0, chg_flags 0, irq_en 0, debug_out 0, avs_readdata 0, irq 0. All sync/debounce counters cleared; per-channel init flag cleared.
- Sync: 2-flop synchroniser per bit. Synchronised value s is taken 2 cycles after the pin.
- Debounce, per channel: counter cnt clears when s != s(previous cycle); otherwise saturating increment. When cnt == DEB_CYCLES-1 and s != stable: stable <= s in the next cycle, and cnt clears.
- Total pin-to-stable latency for a clean edge: 2 + DEB_CYCLES cycles.
- Bounce (s changes mid-count, including back to stable): count restarts; no update.
- Init: the first acceptance after reset (or after DEB_CYCLES stable cycles equal to 0) sets the init flag. It does not set chg_flag or debug_out, which avoids a spurious power-up event. Later acceptances set chg_flags[k] and reload the stretch counter.
- debug_out[k] = 1 while the stretch counter is nonzero. A new change during stretch reloads it to STRETCH.
- Register map (word address):
  - 0..N_CH-1: RO stable value of channel addr, zero-extended to 32 bits.
  - N_CH: chg_flags[N_CH-1:0]. Read returns the flags; write-1-to-clear.
  - N_CH+1: irq_en[N_CH-1:0], RW.
  - Other addresses: read 0; writes ignored.
- Simultaneous W1C and new change on the same bit in the same cycle: set wins, flag stays 1.
- Read of stable value in the same cycle it updates: returns the old value (registered read).
- Read and write asserted together: both honoured. Read returns pre-write contents.
- irq is combinational from registered flags/enables: it asserts 1 cycle after a flag sets and drops 1 cycle after the clearing write.
- Reset mid-debounce or mid-stretch: everything returns to reset values immediately.

Decomposition:
- Package id_switch_pkg holds:
  - register offset functions: VAL_BASE=0, CHG_OFS(n)=n, IRQEN_OFS(n)=n+1;
  - the 32-bit data width constant;
  - the counter width function clog2(DEB_CYCLES), clog2(STRETCH).
- Sub-module id_switch_debounce (one channel, params SW_W, DEB_CYCLES, STRETCH) contains the synchroniser, debounce counter, stable register, init flag, change pulse and stretch counter.
- Top instantiates N_CH copies via generate and adds the Avalon register file and irq.

Test Plan:
- Reset then sw=0x5 on ch0 held (DEB_CYCLES=8) -> stable0=5 at cycle 10. chg_flags=0 (init), debug_out=0.
- After init, ch1 0x3->0xA clean -> after 10 cycles read addr1=0xA. Read addr N_CH=0x2. debug_out[1] high for exactly STRETCH cycles.
- Ch0 toggles 5->6 for 5 cycles then back to 5 -> no update, chg_flags=0, irq=0.
- irq_en=0x3, change ch0 -> irq=1. Write 0x1 to addr N_CH in the same cycle as a new ch0 acceptance -> flag stays 1. A later write 0x1 -> irq=0 next cycle.
- Read addr N_CH+2 and above -> 0. Write there -> no register changes.
- Assert reset during stretch and mid-count -> debug_out, irq, flags and stable all 0 immediately. Re-acceptance is treated as init (no flag).
